l2_evict_buffer: RTL and testbench
==================================

Name: l2_evict_buffer

Overview:
- Parametrised multi-entry eviction write buffer for the L2 cache. It replaces the single-entry EWB.
- Dirty victim lines enter from the L2 controller and are held in a circular FIFO. They drain autonomously to physical memory over the pmem write handshake.
- A tag CAM forwards buffered lines back to the L2 on lookup.
- New behaviour over the single-entry EWB: enqueue-time coalescing of same-tag lines, and a drain-hold input so the controller can prioritise read misses.

Parameters:
- DEPTH, 4, number of line entries; power of two, ≥2.
- LINE_W, 256, line width in bits.
- OFFSET_W, 5, byte-offset bits; TAG_W = 32-OFFSET_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enq_valid_i  in  1  controller presents a victim line.
- enq_ready_o  out  1  buffer can accept; transfer when valid&ready.
- enq_tag_i  in  TAG_W  victim line address [31:OFFSET_W].
- enq_data_i  in  LINE_W  victim line data.
- lookup_i  in  1  tag check request.
- lookup_tag_i  in  TAG_W  tag to check.
- hit_o  out  1  a valid entry matches lookup_tag_i (qualified by lookup_i).
- hit_data_o  out  LINE_W  data of the matching entry.
- hold_i  in  1  inhibit starting a new drain.
- pmem_address  out  32  {head tag, OFFSET_W'b0}.
- pmem_wdata  out  LINE_W  head entry data.
- pmem_write  out  1  write request to memory.
- pmem_resp  in  1  memory write complete.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- empty_o  out  1  count_o==0.

Behaviour:
- Storage: DEPTH entries of {valid, tag, data}, with head/tail pointers wrapping modulo DEPTH.
- enq_ready_o = (count_o < DEPTH) | coalesce_hit. It is combinational; there is no same-cycle pass-through of a freed slot.
- coalesce_hit: enq_tag_i matches a valid entry that is not the head currently being drained (pmem_write=1).
  - On handshake, that entry's data is overwritten in place.
  - Count and pointers are unchanged.
  - At most one non-draining entry per tag can therefore exist.
- Otherwise, an accepted line is written at tail; tail increments and count increments.
- Drain FSM, IDLE -> WRITE -> IDLE:
  - IDLE: if !empty && !hold_i, go to WRITE next cycle with pmem_write=1.
  - WRITE: pmem_write, pmem_address and pmem_wdata are registered from head and stay stable until pmem_resp.
  - WRITE: hold_i is ignored once WRITE has been entered.
  - On pmem_resp, pop head (valid=0, head++, count--), drop pmem_write the following cycle, and return to IDLE.
  - Minimum one IDLE cycle between writes.
- Simultaneous enqueue and pop in the same cycle: count is unchanged, both pointers advance, and enq_ready_o is still evaluated from the pre-pop count.
- Lookup:
  - Combinational over the registered state only; a same-cycle enqueue is not visible.
  - If both the draining head and a younger entry match, the younger entry's data is returned.
  - hit_o=0 when lookup_i=0.
  - hit_data_o is don't-care on miss and is driven to 0.
- The head being drained still hits on lookup until the cycle after pmem_resp.
- Reset (asynchronous, active-low) clears the following:
  - all valid bits, head, tail and count;
  - pmem_write=0, pmem_address=0, pmem_wdata=0;
  - FSM to IDLE; enq_ready_o=1, hit_o=0, empty_o=1.
- Reset during WRITE abandons the write; the memory side must tolerate the dropped request.
- pmem_resp in IDLE is ignored.

Test Plan:
- Reset, then enqueue tags 0x100 and 0x200 with data A and B, hold_i=0 -> pmem_write asserts with pmem_address=0x2000 and data A. After resp: address 0x4000, data B, then empty_o=1.
- hold_i=1, enqueue DEPTH=4 distinct tags -> count_o=4, enq_ready_o=0. A fifth distinct tag stalls. Enqueue of an already-buffered tag with data C is accepted (coalesce), count stays 4, and a later lookup returns C.
- Lookup tag 0x200 while it sits in the buffer -> hit_o=1 and hit_data_o=B. Lookup tag 0x300 -> hit_o=0.
- While head tag 0x100 is draining (pmem_write=1), enqueue 0x100 with data D:
  - new entry allocated, count increments, pmem_wdata remains A;
  - lookup 0x100 returns D.
- Full buffer, pmem_resp and a stalled enqueue in the same cycle -> enq_ready_o=0 that cycle and 1 the next; the enqueue lands with count back at 4.
- Deassert rst_n mid-WRITE -> pmem_write=0 immediately, count_o=0, hit_o=0. After release, the next enqueue drains normally.

Source files
------------

// File: rtl/l2_evict_buffer.sv
// l2_evict_buffer: multi-entry L2 eviction write buffer with tag-CAM forwarding,
// enqueue-time coalescing and a hold-able drain to pmem.
module l2_evict_buffer #(
  parameter int DEPTH    = 4,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5,
  localparam int TAG_W   = 32 - OFFSET_W,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [TAG_W-1:0]  enq_tag_i,
  input  logic [LINE_W-1:0] enq_data_i,
  input  logic              lookup_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] hit_data_o,
  input  logic              hold_i,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [CW-1:0]     count_o,
  output logic              empty_o
);
  typedef enum logic {IDLE, WRITE} state_e;
  state_e              state_q;
  logic [DEPTH-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [DEPTH];
  logic [LINE_W-1:0]   data_q [DEPTH];
  logic [PW-1:0]       head_q, tail_q, coal_idx, lk_idx, wr_idx;
  logic [CW-1:0]       count_q;
  logic                coal_hit, lk_young, head_match, enq_fire, alloc, pop, head_coal;
  // The entry currently being written to pmem is excluded from coalescing so the
  // in-flight data stays stable; lookups prefer the younger copy of a tag.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    lk_young = 1'b0;
    lk_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(pmem_write && PW'(i) == head_q)) begin
        if (tag_q[i] == enq_tag_i) begin
          coal_hit = 1'b1;
          coal_idx = PW'(i);
        end
        if (tag_q[i] == lookup_tag_i) begin
          lk_young = 1'b1;
          lk_idx   = PW'(i);
        end
      end
    end
  end
  assign head_match  = valid_q[head_q] && tag_q[head_q] == lookup_tag_i;
  assign hit_o       = lookup_i && (lk_young || head_match);
  assign hit_data_o  = !hit_o ? '0 : lk_young ? data_q[lk_idx] : data_q[head_q];
  assign enq_ready_o = (count_q < CW'(DEPTH)) | coal_hit;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign alloc       = enq_fire & ~coal_hit;
  assign pop         = (state_q == WRITE) & pmem_resp;
  assign wr_idx      = coal_hit ? coal_idx : tail_q;
  assign head_coal   = enq_fire & coal_hit & (coal_idx == head_q);
  assign count_o     = count_q;
  assign empty_o     = count_q == '0;
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      tag_q[wr_idx]  <= enq_tag_i;
      data_q[wr_idx] <= enq_data_i;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (alloc) valid_q[tail_q] <= 1'b1;
      if (pop) valid_q[head_q] <= 1'b0;
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(alloc);
      count_q <= count_q + CW'(alloc) - CW'(pop);
      if (state_q == IDLE) begin
        if (count_q != '0 && !hold_i) begin
          state_q      <= WRITE;
          pmem_write   <= 1'b1;
          pmem_address <= {tag_q[head_q], {OFFSET_W{1'b0}}};
          // A coalesce into the head on the launch cycle must not be lost.
          pmem_wdata   <= head_coal ? enq_data_i : data_q[head_q];
        end
      end else if (pmem_resp) begin
        state_q    <= IDLE;
        pmem_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_l2_evict_buffer.sv
// tb_l2_evict_buffer: directed vector table plus hand sequences for the eviction buffer.
module tb_l2_evict_buffer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ev = 1'b0, lk = 1'b0, hold = 1'b0, resp = 1'b0;
  logic [26:0]  etag = '0, ltag = '0;
  logic [255:0] edata = '0;
  logic         rdy, hit, pw, empty;
  logic [255:0] hdata, pwdata;
  logic [31:0]  paddr;
  logic [2:0]   cnt;
  int n_chk = 0, n_fail = 0;

  localparam logic [255:0] A = {8{32'hAAAA_0001}};
  localparam logic [255:0] B = {8{32'hBBBB_0002}};
  localparam logic [255:0] C = {8{32'hCCCC_0003}};
  localparam logic [255:0] D = {8{32'hDDDD_0004}};

  l2_evict_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid_i(ev), .enq_ready_o(rdy), .enq_tag_i(etag), .enq_data_i(edata),
    .lookup_i(lk), .lookup_tag_i(ltag), .hit_o(hit), .hit_data_o(hdata),
    .hold_i(hold), .pmem_address(paddr), .pmem_wdata(pwdata), .pmem_write(pw),
    .pmem_resp(resp), .count_o(cnt), .empty_o(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ev; logic [26:0] tag; logic [255:0] dat;
    logic lk; logic [26:0] ltag; logic resp;
    logic rdy; logic hit; logic [255:0] hdat; logic [2:0] cnt;
    logic pw; logic [31:0] addr; logic [255:0] wd;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [26:0] t, input logic [255:0] d,
                       input logic l, input logic [26:0] lt, input logic r);
    @(negedge clk);
    ev = v; etag = t; edata = d; lk = l; ltag = lt; resp = r;
    #1;
  endtask

  function automatic logic [255:0] pd(input int i);
    return {8{32'h5000_0000 + 32'(i)}};
  endfunction

  initial begin
    vt[0] = '{1'b1, 27'h100, A, 1'b0, 27'h0,   1'b0, 1'b1, 1'b0, '0, 3'd0, 1'b0, 32'h0,    '0};
    vt[1] = '{1'b1, 27'h200, B, 1'b1, 27'h100, 1'b0, 1'b1, 1'b1, A,  3'd1, 1'b0, 32'h0,    '0};
    vt[2] = '{1'b0, 27'h0,  '0, 1'b1, 27'h200, 1'b1, 1'b1, 1'b1, B,  3'd2, 1'b1, 32'h2000, A};
    vt[3] = '{1'b0, 27'h0,  '0, 1'b1, 27'h100, 1'b0, 1'b1, 1'b0, '0, 3'd1, 1'b0, 32'h2000, A};
    vt[4] = '{1'b0, 27'h0,  '0, 1'b1, 27'h300, 1'b1, 1'b1, 1'b0, '0, 3'd1, 1'b1, 32'h4000, B};
    vt[5] = '{1'b0, 27'h0,  '0, 1'b1, 27'h200, 1'b0, 1'b1, 1'b0, '0, 3'd0, 1'b0, 32'h4000, B};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", rdy, 1);
    chk("rst_empty", empty, 1);
    chk("rst_pw", pw, 0);
    chk("rst_count", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].ev, vt[i].tag, vt[i].dat, vt[i].lk, vt[i].ltag, vt[i].resp);
      chk($sformatf("v%0d_ready", i), rdy, vt[i].rdy);
      chk($sformatf("v%0d_hit", i), hit, vt[i].hit);
      chk($sformatf("v%0d_hitdata", i), hdata, vt[i].hdat);
      chk($sformatf("v%0d_count", i), cnt, vt[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].cnt == 3'd0);
      chk($sformatf("v%0d_pw", i), pw, vt[i].pw);
      chk($sformatf("v%0d_addr", i), paddr, vt[i].addr);
      chk($sformatf("v%0d_wdata", i), pwdata, vt[i].wd);
    end

    // fill under hold, stall, coalesce
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 27'h10 + 27'(i), pd(i), 0, 0, 0);
      chk("fill_ready", rdy, 1);
    end
    drive(1, 27'h14, pd(4), 0, 0, 0);
    chk("full_count", cnt, 4);
    chk("full_ready", rdy, 0);
    chk("full_pw", pw, 0);
    drive(1, 27'h14, pd(4), 0, 0, 0);
    chk("stall_count", cnt, 4);
    drive(1, 27'h11, C, 0, 0, 0);
    chk("coal_ready", rdy, 1);
    drive(0, 0, '0, 1, 27'h11, 0);
    chk("coal_count", cnt, 4);
    chk("coal_hit", hit, 1);
    chk("coal_data", hdata, C);

    // pop and stalled enqueue in the same cycle
    hold = 1'b0;
    drive(1, 27'h14, pd(4), 0, 0, 0);
    chk("pre_drain_ready", rdy, 0);
    drive(1, 27'h14, pd(4), 0, 0, 1);
    chk("drain_pw", pw, 1);
    chk("drain_addr", paddr, 32'h200);
    chk("pop_cycle_ready", rdy, 0);
    drive(1, 27'h14, pd(4), 0, 0, 0);
    chk("after_pop_ready", rdy, 1);
    chk("after_pop_count", cnt, 3);
    drive(0, 0, '0, 1, 27'h14, 0);
    chk("landed_count", cnt, 4);
    chk("landed_hit", hit, 1);
    chk("landed_data", hdata, pd(4));
    chk("coal_drain_addr", paddr, 32'h220);
    chk("coal_drain_data", pwdata, C);

    // reset mid-write
    drive(0, 0, '0, 1, 27'h12, 0);
    chk("pre_rst_pw", pw, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pw", pw, 0);
    chk("midrst_count", cnt, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_ready", rdy, 1);
    chk("midrst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // coalesce is refused for the draining head
    drive(1, 27'h100, A, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0);
    chk("d_count1", cnt, 1);
    drive(1, 27'h100, D, 0, 0, 0);
    chk("d_pw", pw, 1);
    chk("d_addr", paddr, 32'h2000);
    chk("d_ready", rdy, 1);
    drive(0, 0, '0, 1, 27'h100, 1);
    chk("d_count2", cnt, 2);
    chk("d_wdata_stable", pwdata, A);
    chk("d_lookup_young", hdata, D);
    drive(0, 0, '0, 1, 27'h100, 0);
    chk("d_after_pop_pw", pw, 0);
    chk("d_after_pop_hit", hdata, D);
    drive(0, 0, '0, 0, 0, 1);
    chk("d2_pw", pw, 1);
    chk("d2_addr", paddr, 32'h2000);
    chk("d2_wdata", pwdata, D);
    drive(0, 0, '0, 0, 0, 0);
    chk("d2_empty", empty, 1);
    chk("d2_pw_low", pw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
